cpu_bus_arbiter: RTL and testbench

Two-requester bus arbiter that shares the CPU's single memory bus port between the instruction-fetch path and the load/store data path. It sits between the fetch stage's bus interface and the memory stage's bus interface on one side and the system bus on the other. It grants one complete request/ready transaction at a time and registers the winning requester's address and write data onto the bus. A watchdog aborts a transaction that never completes.

---
 rtl/cpu_bus_arbiter_if.sv | 41 ++++
 rtl/cpu_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between cpu_bus_arbiter and its fetch, data and system-bus neighbours.
// master: the arbiter's view; slave: the view of the requesters and the bus.
interface cpu_bus_arbiter_if;
   logic        i_fetch_request;
   logic        o_fetch_ready;
   logic [31:0] i_fetch_address;
   logic [31:0] o_fetch_rdata;
   logic        i_data_request;
   logic        i_data_rw;
   logic        o_data_ready;
   logic [31:0] i_data_address;
   logic [31:0] i_data_wdata;
   logic [3:0]  i_data_wmask;
   logic [31:0] o_data_rdata;
   logic        o_bus_request;
   logic        o_bus_rw;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_wmask;
   logic        i_bus_ready;
   logic [31:0] i_bus_rdata;
   logic        o_timeout;

   modport master (
      input  i_fetch_request, i_fetch_address,
      input  i_data_request, i_data_rw, i_data_address, i_data_wdata, i_data_wmask,
      input  i_bus_ready, i_bus_rdata,
      output o_fetch_ready, o_fetch_rdata, o_data_ready, o_data_rdata,
      output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
      output o_timeout
   );

   modport slave (
      output i_fetch_request, i_fetch_address,
      output i_data_request, i_data_rw, i_data_address, i_data_wdata, i_data_wmask,
      output i_bus_ready, i_bus_rdata,
      input  o_fetch_ready, o_fetch_rdata, o_data_ready, o_data_rdata,
      input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
      input  o_timeout
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Fetch/data arbiter for the CPU's single bus port, one transaction at a time, with watchdog.
// Optional feature: define CPU_BUS_ARB_ROUND_ROBIN_EN for round-robin instead of data-first priority.
module cpu_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   cpu_bus_arbiter_if.master bus
);
   localparam bit          LP_WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] LP_LIMIT = (TIMEOUT_CYCLES != 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_GRANT_FETCH = 2'd1,
      ST_GRANT_DATA  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_bus_request, w_bus_request_nxt;
   logic        r_bus_rw, w_bus_rw_nxt;
   logic [31:0] r_bus_address, w_bus_address_nxt;
   logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
   logic [3:0]  r_bus_wmask, w_bus_wmask_nxt;
   logic [15:0] r_count, w_count_nxt;
   logic        r_mask_fetch, w_mask_fetch_nxt;
   logic        r_mask_data, w_mask_data_nxt;
   logic        w_eff_fetch, w_eff_data, w_pick_fetch, w_grant;
   logic        w_expire, w_done;
   logic        w_fetch_ready, w_data_ready, w_timeout;
   logic [31:0] w_fetch_rdata, w_data_rdata;

   assign w_eff_fetch = bus.i_fetch_request & ~r_mask_fetch;
   assign w_eff_data  = bus.i_data_request & ~r_mask_data;
   assign w_grant     = (r_state == ST_IDLE) & (w_eff_fetch | w_eff_data);
   assign w_expire    = LP_WD_EN & (r_count == LP_LIMIT);
   assign w_done      = bus.i_bus_ready | w_expire;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
   logic r_last_fetch;

   assign w_pick_fetch = w_eff_fetch & (~w_eff_data | ~r_last_fetch);

   // Round-robin pointer: records whether the latest grant went to fetch.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_last_fetch <= 1'b1;
      end else if (w_grant) begin
         r_last_fetch <= w_pick_fetch;
      end else begin
         r_last_fetch <= r_last_fetch;
      end
   end
`else
   assign w_pick_fetch = w_eff_fetch & ~w_eff_data;
`endif

   // Next-state, bus-register and completion logic.
   always_comb begin
      w_state_nxt       = r_state;
      w_bus_request_nxt = r_bus_request;
      w_bus_rw_nxt      = r_bus_rw;
      w_bus_address_nxt = r_bus_address;
      w_bus_wdata_nxt   = r_bus_wdata;
      w_bus_wmask_nxt   = r_bus_wmask;
      w_count_nxt       = r_count;
      w_mask_fetch_nxt  = 1'b0;
      w_mask_data_nxt   = 1'b0;
      w_fetch_ready     = 1'b0;
      w_data_ready      = 1'b0;
      w_fetch_rdata     = 32'd0;
      w_data_rdata      = 32'd0;
      w_timeout         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_fetch) begin
               w_state_nxt       = ST_GRANT_FETCH;
               w_bus_request_nxt = 1'b1;
               w_bus_rw_nxt      = 1'b0;
               w_bus_address_nxt = bus.i_fetch_address;
               w_bus_wdata_nxt   = 32'd0;
               w_bus_wmask_nxt   = 4'b0000;
               w_count_nxt       = 16'd0;
            end else if (w_eff_data) begin
               w_state_nxt       = ST_GRANT_DATA;
               w_bus_request_nxt = 1'b1;
               w_bus_rw_nxt      = bus.i_data_rw;
               w_bus_address_nxt = bus.i_data_address;
               w_bus_wdata_nxt   = bus.i_data_wdata;
               w_bus_wmask_nxt   = bus.i_data_wmask;
               w_count_nxt       = 16'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT_FETCH, ST_GRANT_DATA: begin
            if (w_done) begin
               // A real ready always beats the watchdog in the same cycle.
               w_timeout         = ~bus.i_bus_ready;
               w_state_nxt       = ST_IDLE;
               w_bus_request_nxt = 1'b0;
               if (r_state == ST_GRANT_FETCH) begin
                  w_fetch_ready    = 1'b1;
                  w_fetch_rdata    = bus.i_bus_ready ? bus.i_bus_rdata : 32'd0;
                  w_mask_fetch_nxt = 1'b1;
               end else begin
                  w_data_ready    = 1'b1;
                  w_data_rdata    = bus.i_bus_ready ? bus.i_bus_rdata : 32'd0;
                  w_mask_data_nxt = 1'b1;
               end
            end else begin
               w_count_nxt = LP_WD_EN ? (r_count + 16'd1) : r_count;
            end
         end
         default: begin
            w_state_nxt       = ST_IDLE;
            w_bus_request_nxt = 1'b0;
         end
      endcase
   end

   // State, bus registers, watchdog counter and post-ready masks.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_bus_request <= 1'b0;
         r_bus_rw      <= 1'b0;
         r_bus_address <= 32'd0;
         r_bus_wdata   <= 32'd0;
         r_bus_wmask   <= 4'b0000;
         r_count       <= 16'd0;
         r_mask_fetch  <= 1'b0;
         r_mask_data   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_bus_request <= w_bus_request_nxt;
         r_bus_rw      <= w_bus_rw_nxt;
         r_bus_address <= w_bus_address_nxt;
         r_bus_wdata   <= w_bus_wdata_nxt;
         r_bus_wmask   <= w_bus_wmask_nxt;
         r_count       <= w_count_nxt;
         r_mask_fetch  <= w_mask_fetch_nxt;
         r_mask_data   <= w_mask_data_nxt;
      end
   end

   // Ready, rdata and timeout are combinational so completion costs no extra cycle.
   assign bus.o_fetch_ready = w_fetch_ready;
   assign bus.o_fetch_rdata = w_fetch_rdata;
   assign bus.o_data_ready  = w_data_ready;
   assign bus.o_data_rdata  = w_data_rdata;
   assign bus.o_timeout     = w_timeout;
   assign bus.o_bus_request = r_bus_request;
   assign bus.o_bus_rw      = r_bus_rw;
   assign bus.o_bus_address = r_bus_address;
   assign bus.o_bus_wdata   = r_bus_wdata;
   assign bus.o_bus_wmask   = r_bus_wmask;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: vector table, corner sequences, randomized run vs model.
module tb_cpu_bus_arbiter;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int T8 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   cpu_bus_arbiter_if if8();
   cpu_bus_arbiter_if if4();

   cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) u_dut8 (.i_clock(clk), .i_reset_n(rst_n), .bus(if8));
   cpu_bus_arbiter #(.TIMEOUT_CYCLES(4)) u_dut4 (.i_clock(clk), .i_reset_n(rst_n), .bus(if4));

   typedef struct {
      logic fr; logic [31:0] fa;
      logic dr; logic rw; logic [31:0] da; logic [31:0] wd; logic [3:0] wm;
      logic rdy; logic [31:0] rd;
   } stim_t;

   typedef struct {
      stim_t s;
      logic req; logic rw; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;
      logic frdy; logic drdy; logic [31:0] frd; logic [31:0] drd; logic to;
   } vec_t;

   function automatic stim_t st(logic fr, logic [31:0] fa, logic dr, logic rw, logic [31:0] da,
                                logic [31:0] wd, logic [3:0] wm, logic rdy, logic [31:0] rd);
      stim_t s;
      s.fr = fr; s.fa = fa; s.dr = dr; s.rw = rw; s.da = da; s.wd = wd; s.wm = wm;
      s.rdy = rdy; s.rd = rd;
      return s;
   endfunction

   function automatic vec_t vc(stim_t s, logic req, logic rw, logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] wmask, logic frdy, logic drdy, logic [31:0] frd,
                               logic [31:0] drd, logic to);
      vec_t v;
      v.s = s; v.req = req; v.rw = rw; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
      v.frdy = frdy; v.drdy = drdy; v.frd = frd; v.drd = drd; v.to = to;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply8(input stim_t s);
      if8.i_fetch_request = s.fr; if8.i_fetch_address = s.fa;
      if8.i_data_request = s.dr; if8.i_data_rw = s.rw; if8.i_data_address = s.da;
      if8.i_data_wdata = s.wd; if8.i_data_wmask = s.wm;
      if8.i_bus_ready = s.rdy; if8.i_bus_rdata = s.rd;
   endtask

   task automatic zero_inputs();
      apply8(st(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0));
      if4.i_fetch_request = 1'b0; if4.i_fetch_address = 32'd0;
      if4.i_data_request = 1'b0; if4.i_data_rw = 1'b0; if4.i_data_address = 32'd0;
      if4.i_data_wdata = 32'd0; if4.i_data_wmask = 4'd0;
      if4.i_bus_ready = 1'b0; if4.i_bus_rdata = 32'd0;
   endtask

   task automatic check8(input string tag, input vec_t v);
      chk({tag, ".bus_request"}, 32'(if8.o_bus_request), 32'(v.req));
      chk({tag, ".bus_rw"}, 32'(if8.o_bus_rw), 32'(v.rw));
      chk({tag, ".bus_address"}, if8.o_bus_address, v.addr);
      chk({tag, ".bus_wdata"}, if8.o_bus_wdata, v.wdata);
      chk({tag, ".bus_wmask"}, 32'(if8.o_bus_wmask), 32'(v.wmask));
      chk({tag, ".fetch_ready"}, 32'(if8.o_fetch_ready), 32'(v.frdy));
      chk({tag, ".data_ready"}, 32'(if8.o_data_ready), 32'(v.drdy));
      chk({tag, ".fetch_rdata"}, if8.o_fetch_rdata, v.frd);
      chk({tag, ".data_rdata"}, if8.o_data_rdata, v.drd);
      chk({tag, ".timeout"}, 32'(if8.o_timeout), 32'(v.to));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      zero_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t  vt[$];
      stim_t z;
      vec_t  zv;
      int    order[4];
      int    n_ord;
      // reference model state
      int          m_owner, m_el, m_mask, m_last;
      logic        m_req, m_rw;
      logic [31:0] m_addr, m_wdata;
      logic [3:0]  m_wmask;
      int          fs, ds, lat;
      logic [31:0] fa, da, dw, rd;
      logic [3:0]  dm;
      logic        drw, rdy;

      z  = st(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
      zv = vc(z, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // ---------------- vector table ----------------
      vt.push_back(vc(st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) vt.push_back(vc(st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF), 1, 0, 32'h100, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0));
      vt.push_back(vc(st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(0, 0, 1, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 0, 0),
                      0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(0, 0, 1, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 1, 32'hAAAA_5555),
                      1, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 0, 1, 0, 32'hAAAA_5555, 0));
      vt.push_back(vc(st(0, 0, 1, 1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0),
                      0, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h55),
                      0, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),
                      0, 1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0));
      // simultaneous requests after a data grant: round-robin picks fetch, fixed picks data
      vt.push_back(vc(st(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h11),
                      1, 0, RR ? 32'h200 : 32'h300, 0, RR ? 4'h0 : 4'hF,
                      RR, !RR, RR ? 32'h11 : 32'h0, RR ? 32'h0 : 32'h11, 0));
      vt.push_back(vc(st(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),
                      0, 0, RR ? 32'h200 : 32'h300, 0, RR ? 4'h0 : 4'hF, 0, 0, 0, 0, 0));
      vt.push_back(vc(st(!RR, 32'h200, RR, 0, 32'h300, 0, 4'hF, 1, 32'h22),
                      1, 0, RR ? 32'h300 : 32'h200, 0, RR ? 4'hF : 4'h0,
                      !RR, RR, RR ? 32'h0 : 32'h22, RR ? 32'h22 : 32'h0, 0));
      vt.push_back(vc(z, 0, 0, RR ? 32'h300 : 32'h200, 0, RR ? 4'hF : 4'h0, 0, 0, 0, 0, 0));

      zero_inputs();
      #2;
      check8("reset", zv);
      do_reset();
      foreach (vt[i]) begin
         @(posedge clk); #1;
         apply8(vt[i].s);
         @(negedge clk);
         check8($sformatf("vec%0d", i), vt[i]);
      end

      // ---------------- both requesting continuously, zero-wait bus ----------------
      // the post-ready mask hands the dead cycle to the other requester in both modes
      do_reset();
      @(posedge clk); #1;
      apply8(st(1, 32'h1000, 1, 0, 32'h2000, 0, 4'hF, 0, 0));
      n_ord = 0;
      for (int c = 0; c < 40 && n_ord < 4; c++) begin
         @(posedge clk); #1;
         if8.i_bus_ready = if8.o_bus_request;
         @(negedge clk);
         chk("both_ready_exclusive", 32'(if8.o_fetch_ready & if8.o_data_ready), 32'd0);
         if (if8.o_data_ready && n_ord < 4) begin order[n_ord] = 2; n_ord++; end
         if (if8.o_fetch_ready && n_ord < 4) begin order[n_ord] = 1; n_ord++; end
      end
      chk("order_count", 32'(n_ord), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("order%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd2 : 32'd1);

      // ---------------- watchdog abort at grant cycle 8 ----------------
      do_reset();
      @(posedge clk); #1;
      if8.i_fetch_request = 1'b1; if8.i_fetch_address = 32'h500;
      for (int g = 1; g <= 8; g++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("wd_g%0d.bus_request", g), 32'(if8.o_bus_request), 32'd1);
         chk($sformatf("wd_g%0d.fetch_ready", g), 32'(if8.o_fetch_ready), 32'(g == 8));
         chk($sformatf("wd_g%0d.timeout", g), 32'(if8.o_timeout), 32'(g == 8));
      end
      chk("wd.fetch_rdata", if8.o_fetch_rdata, 32'd0);
      @(posedge clk); #1;
      if8.i_fetch_request = 1'b0; if8.i_bus_ready = 1'b1; if8.i_bus_rdata = 32'h77;
      @(negedge clk);
      check8("wd_late", vc(z, 0, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      if8.i_bus_ready = 1'b0;
      @(negedge clk);
      chk("wd_after.bus_request", 32'(if8.o_bus_request), 32'd0);

      // ---------------- reset in the middle of a grant ----------------
      do_reset();
      @(posedge clk); #1;
      if8.i_fetch_request = 1'b1; if8.i_fetch_address = 32'h600;
      repeat (2) @(posedge clk);
      #1 if8.i_bus_ready = 1'b1; if8.i_bus_rdata = 32'h1357_9BDF;
      #1 rst_n = 1'b0;
      #1 check8("midrst", zv);
      if8.i_bus_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("postrst.bus_request", 32'(if8.o_bus_request), 32'd1);
      chk("postrst.bus_address", if8.o_bus_address, 32'h600);
      @(posedge clk); #1;
      if8.i_bus_ready = 1'b1; if8.i_bus_rdata = 32'h2468_ACE0;
      @(negedge clk);
      chk("postrst.fetch_rdata", if8.o_fetch_rdata, 32'h2468_ACE0);
      @(posedge clk); #1;
      zero_inputs();

      // ---------------- ready coinciding with the 4-cycle watchdog limit ----------------
      do_reset();
      @(posedge clk); #1;
      if4.i_fetch_request = 1'b1; if4.i_fetch_address = 32'h700;
      for (int g = 1; g <= 4; g++) begin
         @(posedge clk); #1;
         if4.i_bus_ready = (g == 4); if4.i_bus_rdata = 32'hCAFE_F00D;
         @(negedge clk);
         chk($sformatf("co_g%0d.bus_request", g), 32'(if4.o_bus_request), 32'd1);
         chk($sformatf("co_g%0d.fetch_ready", g), 32'(if4.o_fetch_ready), 32'(g == 4));
         chk($sformatf("co_g%0d.timeout", g), 32'(if4.o_timeout), 32'd0);
      end
      chk("co.fetch_rdata", if4.o_fetch_rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
      if4.i_fetch_request = 1'b0; if4.i_bus_ready = 1'b0;
      @(negedge clk);
      chk("co_after.bus_request", 32'(if4.o_bus_request), 32'd0);

      // ---------------- randomized run against the reference model ----------------
      do_reset();
      m_owner = 0; m_el = 0; m_mask = 0; m_last = 1;
      m_req = 1'b0; m_rw = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_wmask = 4'd0;
      fs = 0; ds = 0; lat = 0; fa = 32'd0; da = 32'd0; dw = 32'd0; dm = 4'd0; drw = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         vec_t e;
         logic done, feff, deff;
         int   win;
         @(posedge clk); #1;
         if (fs == 0 && $urandom_range(0, 3) == 0) begin fs = 1; fa = $urandom; end
         if (ds == 0 && $urandom_range(0, 2) == 0) begin
            ds = 1; da = $urandom; dw = $urandom; dm = 4'($urandom); drw = 1'($urandom);
         end
         if (m_owner != 0 && m_el == 0) lat = $urandom_range(0, 9);
         rdy = (m_owner != 0) ? (m_el == lat) : ($urandom_range(0, 7) == 0);
         rd  = $urandom;
         apply8(st(fs != 0, fa, ds != 0, drw, da, dw, dm, rdy, rd));
         @(negedge clk);

         done = (m_owner != 0) && (rdy || m_el == T8 - 1);
         e = vc(z, m_req, m_rw, m_addr, m_wdata, m_wmask,
                done && m_owner == 1, done && m_owner == 2,
                (done && m_owner == 1 && rdy) ? rd : 32'd0,
                (done && m_owner == 2 && rdy) ? rd : 32'd0,
                (m_owner != 0) && !rdy && (m_el == T8 - 1));
         check8($sformatf("rnd%0d", cyc), e);

         if (m_owner != 0) begin
            if (done) begin m_mask = m_owner; m_owner = 0; m_req = 1'b0; end
            else m_el++;
         end else begin
            feff = (fs != 0) && (m_mask != 1);
            deff = (ds != 0) && (m_mask != 2);
            m_mask = 0;
            if (feff && deff) win = RR ? ((m_last == 2) ? 1 : 2) : 2;
            else win = feff ? 1 : (deff ? 2 : 0);
            if (win == 1) begin
               m_owner = 1; m_el = 0; m_last = 1; m_req = 1'b1;
               m_rw = 1'b0; m_addr = fa; m_wdata = 32'd0; m_wmask = 4'd0;
            end else if (win == 2) begin
               m_owner = 2; m_el = 0; m_last = 2; m_req = 1'b1;
               m_rw = drw; m_addr = da; m_wdata = dw; m_wmask = dm;
            end
         end

         if (fs == 2) fs = 0;
         else if (fs == 1 && e.frdy) fs = ($urandom_range(0, 1) == 1) ? 2 : 0;
         if (ds == 2) ds = 0;
         else if (ds == 1 && e.drdy) ds = ($urandom_range(0, 1) == 1) ? 2 : 0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
